io_stepper_hub: RTL and testbench



---
 rtl/io_pkg.sv | 41 ++++
 rtl/stepper_channel.sv | 156 +++++++++++++++
 rtl/io_stepper_hub.sv | 103 ++++++++++
 tb/tb_io_stepper_hub.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared definitions for the stepper IO hub: register map, status bit
// positions, command/control field positions and the channel state type.
package io_pkg;

  localparam int unsigned IO_BIT_DEF = 12;

  localparam logic [1:0] REG_CMD    = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int unsigned ST_BUSY = 31;
  localparam int unsigned ST_DONE = 30;
  localparam int unsigned ST_ERR  = 29;
  localparam int unsigned ST_DIR  = 28;

  localparam int unsigned CMD_DIR    = 31;
  localparam int unsigned CTRL_ABORT = 0;
  localparam int unsigned CTRL_CLEAR = 1;

  typedef enum logic [1:0] {
    CH_IDLE = 2'd0,
    CH_HIGH = 2'd1,
    CH_LOW  = 2'd2
  } ch_state_e;

  // Status word: flags in the top nibble, remaining count zero-extended below.
  function automatic logic [31:0] pack_status(input logic busy, input logic done,
                                              input logic err, input logic dir,
                                              input logic [27:0] rem);
    logic [31:0] s;
    s          = '0;
    s[27:0]    = rem;
    s[ST_BUSY] = busy;
    s[ST_DONE] = done;
    s[ST_ERR]  = err;
    s[ST_DIR]  = dir;
    return s;
  endfunction

endpackage

// File: rtl/stepper_channel.sv
// One stepper channel: step-pulse sequencer with programmable count, period
// and direction, plus sticky done/err flags.
module stepper_channel
  import io_pkg::*;
#(
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DIV_W      = 20,
  parameter int unsigned PULSE_W    = 100,
  parameter int unsigned DEF_PERIOD = 100000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_we,
  input  logic [CNT_W-1:0] cmd_steps,
  input  logic             cmd_dir,
  input  logic             period_we,
  input  logic [DIV_W-1:0] period_wdata,
  input  logic             abort,
  input  logic             clear,
  output logic             step,
  output logic             dir,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             done_nxt_c,
  output logic [CNT_W-1:0] remaining,
  output logic [DIV_W-1:0] period
);

  localparam logic [DIV_W-1:0] PULSE_LAST = DIV_W'(PULSE_W - 1);
  localparam logic [DIV_W-1:0] MIN_PERIOD = DIV_W'(PULSE_W + 1);

  ch_state_e        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             step_q, step_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic [DIV_W-1:0] peff_c;
  logic [DIV_W-1:0] peff_last_c;

  // The period must leave at least one low cycle after the pulse.
  assign peff_c      = (period_q < MIN_PERIOD) ? MIN_PERIOD : period_q;
  assign peff_last_c = peff_c - DIV_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    rem_d    = rem_q;
    step_d   = step_q;
    dir_d    = dir_q;
    done_d   = done_q;
    err_d    = err_q;

    case (state_q)
      CH_IDLE: begin
        step_d = 1'b0;
        if (cmd_we) begin
          if (cmd_steps != '0) begin
            state_d = CH_HIGH;
            cnt_d   = '0;
            rem_d   = cmd_steps;
            dir_d   = cmd_dir;
            done_d  = 1'b0;
            step_d  = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      CH_HIGH: begin
        cnt_d = cnt_q + DIV_W'(1);
        if (cnt_q == PULSE_LAST) begin
          state_d = CH_LOW;
          step_d  = 1'b0;
        end
      end
      CH_LOW: begin
        // >= keeps a shortened period from stranding the counter past its end.
        if (cnt_q >= peff_last_c) begin
          cnt_d = '0;
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) begin
            state_d = CH_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = CH_HIGH;
            step_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = CH_IDLE;
        step_d  = 1'b0;
      end
    endcase

    if (cmd_we && (state_q != CH_IDLE)) err_d = 1'b1;
    if (period_we) period_d = period_wdata;

    if (abort && (state_q != CH_IDLE)) begin
      state_d = CH_IDLE;
      step_d  = 1'b0;
      cnt_d   = '0;
      rem_d   = '0;
      done_d  = done_q;
    end

    if (clear) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end

    busy_d = (state_d != CH_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= CH_IDLE;
      cnt_q    <= '0;
      period_q <= DIV_W'(DEF_PERIOD);
      rem_q    <= '0;
      step_q   <= 1'b0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      rem_q    <= rem_d;
      step_q   <= step_d;
      dir_q    <= dir_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign step       = step_q;
  assign dir        = dir_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign done_nxt_c = done_d;
  assign remaining  = rem_q;
  assign period     = period_q;

endmodule

// File: rtl/io_stepper_hub.sv
// Memory-mapped hub of NUM_CH stepper channels: address decode, channel
// instances, zero-latency status read mux and the shared done interrupt.
module io_stepper_hub
  import io_pkg::*;
#(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned DIV_W      = 20,
  parameter int unsigned PULSE_W    = 100,
  parameter int unsigned IO_BIT     = IO_BIT_DEF,
  parameter int unsigned DEF_PERIOD = 100000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              io_insn,
  input  logic              io_we,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       data_in,
  output logic [31:0]       data_out,
  output logic [NUM_CH-1:0] step,
  output logic [NUM_CH-1:0] dir,
  output logic              irq
);

  logic [2:0]        ch_idx_c;
  logic [1:0]        reg_idx_c;
  logic              sel_c;
  logic              wr_c;
  logic              rd_c;
  logic [NUM_CH-1:0] busy_w;
  logic [NUM_CH-1:0] done_w;
  logic [NUM_CH-1:0] err_w;
  logic [NUM_CH-1:0] done_nxt_w;
  logic [CNT_W-1:0]  rem_w [NUM_CH];
  logic [DIV_W-1:0]  per_w [NUM_CH];
  logic              irq_q, irq_d;
  logic              unused_bits;

  // Address bits outside the decoded fields and data bits beyond the fields are don't-care.
  assign unused_bits = ^{mem_addr, data_in};

  assign ch_idx_c  = mem_addr[6:4];
  assign reg_idx_c = mem_addr[3:2];
  assign sel_c     = io_insn & mem_addr[IO_BIT] & ({1'b0, ch_idx_c} < 4'(NUM_CH));
  assign wr_c      = sel_c & io_we;
  assign rd_c      = sel_c & ~io_we;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic hit_c;
    assign hit_c = wr_c && (ch_idx_c == 3'(i));

    stepper_channel #(
      .CNT_W      (CNT_W),
      .DIV_W      (DIV_W),
      .PULSE_W    (PULSE_W),
      .DEF_PERIOD (DEF_PERIOD)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .cmd_we       (hit_c && (reg_idx_c == REG_CMD)),
      .cmd_steps    (data_in[CNT_W-1:0]),
      .cmd_dir      (data_in[CMD_DIR]),
      .period_we    (hit_c && (reg_idx_c == REG_PERIOD)),
      .period_wdata (data_in[DIV_W-1:0]),
      .abort        (hit_c && (reg_idx_c == REG_CTRL) && data_in[CTRL_ABORT]),
      .clear        (hit_c && (reg_idx_c == REG_CTRL) && data_in[CTRL_CLEAR]),
      .step         (step[i]),
      .dir          (dir[i]),
      .busy         (busy_w[i]),
      .done         (done_w[i]),
      .err          (err_w[i]),
      .done_nxt_c   (done_nxt_w[i]),
      .remaining    (rem_w[i]),
      .period       (per_w[i])
    );
  end

  // Read mux; write-only registers and unselected accesses read as zero.
  always_comb begin
    data_out = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_c && (ch_idx_c == 3'(i))) begin
        case (reg_idx_c)
          REG_PERIOD: data_out = 32'(per_w[i]);
          REG_STATUS: data_out = pack_status(busy_w[i], done_w[i], err_w[i], dir[i],
                                             28'(rem_w[i]));
          default:    data_out = '0;
        endcase
      end
    end
  end

  // Built from next-state done so irq changes on the same edge as the flags.
  assign irq_d = |done_nxt_w;

  always_ff @(posedge clk) begin
    if (!rst_n) irq_q <= 1'b0;
    else        irq_q <= irq_d;
  end

  assign irq = irq_q;

endmodule

// File: tb/tb_io_stepper_hub.sv
// Self-checking bench for io_stepper_hub: register table, directed corner
// sequences and a randomized run against a cycle-level behavioural model.
module tb_io_stepper_hub;

  localparam int NCH   = 4;
  localparam int PW    = 2;
  localparam int DEFP  = 100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        io_insn = 1'b0;
  logic        io_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out;
  logic [3:0]  step;
  logic [3:0]  dir;
  logic        irq;

  io_stepper_hub #(
    .NUM_CH(NCH), .CNT_W(16), .DIV_W(20), .PULSE_W(PW), .IO_BIT(12), .DEF_PERIOD(DEFP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .io_insn(io_insn), .io_we(io_we), .mem_addr(mem_addr),
    .data_in(data_in), .data_out(data_out), .step(step), .dir(dir), .irq(irq)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Behavioural model: per channel, a busy flag, steps left, and the cycle
  // offset t within the current step; the pulse is high while t < PW.
  logic [3:0] m_busy, m_done, m_err, m_dir;
  logic       m_irq;
  int         m_rem [NCH];
  int         m_t   [NCH];
  int         m_per [NCH];

  logic [31:0] obs_data;
  logic [3:0]  obs_step, obs_dir;
  logic        obs_irq;

  int rises_a [NCH];
  int high_a  [NCH];
  int gmin_a  [NCH];
  int gmax_a  [NCH];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic int peff(input int p);
    return (p < PW + 1) ? PW + 1 : p;
  endfunction

  function automatic logic [31:0] io_a(input int ch, input int r);
    return 32'h1000 | 32'(ch << 4) | 32'(r << 2);
  endfunction

  task automatic m_reset();
    m_busy = '0; m_done = '0; m_err = '0; m_dir = '0; m_irq = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      m_rem[k] = 0; m_t[k] = 0; m_per[k] = DEFP;
    end
  endtask

  function automatic logic [3:0] m_step();
    logic [3:0] s;
    s = '0;
    for (int k = 0; k < NCH; k++) s[k] = m_busy[k] && (m_t[k] < PW);
    return s;
  endfunction

  function automatic logic [31:0] m_read(input logic insn, input logic we, input logic [31:0] a);
    int c;
    int r;
    c = int'(a[6:4]);
    r = int'(a[3:2]);
    if (!insn || we || !a[12] || c >= NCH) return 32'h0;
    if (r == 1) return 32'(m_per[c]);
    if (r == 2) return {m_busy[c], m_done[c], m_err[c], m_dir[c], 12'h000, 16'(m_rem[c])};
    return 32'h0;
  endfunction

  task automatic m_edge(input logic rst, input logic insn, input logic we,
                        input logic [31:0] a, input logic [31:0] d);
    int   c;
    int   r;
    logic wr;
    logic was_busy;
    logic fin;
    if (!rst) begin
      m_reset();
      return;
    end
    c  = int'(a[6:4]);
    r  = int'(a[3:2]);
    wr = insn && we && a[12] && (c < NCH);
    for (int k = 0; k < NCH; k++) begin
      was_busy = m_busy[k];
      fin = 1'b0;
      if (m_busy[k]) begin
        if (m_t[k] >= peff(m_per[k]) - 1) begin
          m_t[k] = 0;
          m_rem[k] = m_rem[k] - 1;
          if (m_rem[k] == 0) begin
            m_busy[k] = 1'b0;
            fin = 1'b1;
          end
        end else begin
          m_t[k] = m_t[k] + 1;
        end
      end
      if (wr && c == k) begin
        if (r == 0) begin
          if (was_busy) m_err[k] = 1'b1;
          else if (d[15:0] != 16'h0) begin
            m_busy[k] = 1'b1; m_rem[k] = int'(d[15:0]); m_t[k] = 0;
            m_dir[k] = d[31]; m_done[k] = 1'b0;
          end else fin = 1'b1;
        end else if (r == 1) begin
          m_per[k] = int'(d[19:0]);
        end else if (r == 3) begin
          if (d[0] && was_busy) begin
            m_busy[k] = 1'b0; m_rem[k] = 0; m_t[k] = 0; fin = 1'b0;
          end
          if (d[1]) begin
            m_done[k] = 1'b0; m_err[k] = 1'b0; fin = 1'b0;
          end
        end
      end
      if (fin) m_done[k] = 1'b1;
    end
    m_irq = |m_done;
  endtask

  // One clock: drive on the falling edge, check against the model, then advance it.
  task automatic cycle(input logic rst, input logic insn, input logic we,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    rst_n = rst; io_insn = insn; io_we = we; mem_addr = a; data_in = d;
    #1;
    obs_data = data_out; obs_step = step; obs_dir = dir; obs_irq = irq;
    chk("step", 32'(step), 32'(m_step()));
    chk("dir", 32'(dir), 32'(m_dir));
    chk("irq", 32'(irq), 32'(m_irq));
    chk("data_out", data_out, m_read(insn, we, a));
    @(posedge clk);
    m_edge(rst, insn, we, a, d);
  endtask

  task automatic wr(input int ch, input int r, input logic [31:0] d);
    cycle(1'b1, 1'b1, 1'b1, io_a(ch, r), d);
  endtask

  task automatic rd(input int ch, input int r);
    cycle(1'b1, 1'b1, 1'b0, io_a(ch, r), 32'h0);
  endtask

  // Idle for n cycles, tallying rising edges, high cycles and edge spacing per channel.
  task automatic idle_count(input int n);
    int   last [NCH];
    logic prev [NCH];
    for (int k = 0; k < NCH; k++) begin
      rises_a[k] = 0; high_a[k] = 0; gmin_a[k] = 1000000; gmax_a[k] = 0;
      last[k] = -1; prev[k] = obs_step[k];
    end
    for (int i = 0; i < n; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      for (int k = 0; k < NCH; k++) begin
        if (obs_step[k] && !prev[k]) begin
          if (last[k] >= 0) begin
            if (i - last[k] < gmin_a[k]) gmin_a[k] = i - last[k];
            if (i - last[k] > gmax_a[k]) gmax_a[k] = i - last[k];
          end
          last[k] = i;
          rises_a[k]++;
        end
        if (obs_step[k]) high_a[k]++;
        prev[k] = obs_step[k];
      end
    end
  endtask

  typedef struct {
    logic        insn;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] exp_data;
    logic        exp_irq;
  } vec_t;

  vec_t tbl [14];

  initial begin
    int          ra;
    int          rsel;
    int          ch;
    int          rg;
    logic        rwe;
    logic [31:0] ra_addr;
    logic [31:0] rd_data;

    tbl[0]  = '{1'b1, 1'b0, 32'h1008, 32'h0,  32'h0,          1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h1004, 32'h0,  32'(DEFP),      1'b0};
    tbl[2]  = '{1'b1, 1'b1, 32'h1014, 32'd10, 32'h0,          1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h1014, 32'h0,  32'd10,         1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0014, 32'h0,  32'h0,          1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h1074, 32'h0,  32'h0,          1'b0};
    tbl[6]  = '{1'b1, 1'b1, 32'h1074, 32'd5,  32'h0,          1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h1074, 32'h0,  32'h0,          1'b0};
    tbl[8]  = '{1'b1, 1'b1, 32'h1020, 32'h0,  32'h0,          1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h1028, 32'h0,  32'h4000_0000,  1'b1};
    tbl[10] = '{1'b1, 1'b1, 32'h102C, 32'd2,  32'h0,          1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h1028, 32'h0,  32'h0,          1'b0};
    tbl[12] = '{1'b1, 1'b0, 32'h1000, 32'h0,  32'h0,          1'b0};
    tbl[13] = '{1'b0, 1'b0, 32'h1004, 32'h0,  32'h0,          1'b0};

    m_reset();
    obs_step = '0;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, tbl[i].insn, tbl[i].we, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_data", i), obs_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d_irq", i), 32'(obs_irq), 32'(tbl[i].exp_irq));
    end

    // Three steps on ch1, period 10, dir 1.
    wr(1, 0, 32'h8000_0003);
    idle_count(40);
    chk("t2_rises", 32'(rises_a[1]), 32'd3);
    chk("t2_high", 32'(high_a[1]), 32'd6);
    chk("t2_gap_min", 32'(gmin_a[1]), 32'd10);
    chk("t2_gap_max", 32'(gmax_a[1]), 32'd10);
    rd(1, 2);
    chk("t2_status", obs_data, 32'h5000_0000);
    chk("t2_irq", 32'(obs_irq), 32'd1);
    chk("t2_dir", 32'(obs_dir[1]), 32'd1);

    // Abort a long move on ch0 while the pulse is high.
    wr(0, 1, 32'd10);
    wr(0, 0, 32'd100);
    idle_count(20);
    chk("t3_rises", 32'(rises_a[0]), 32'd2);
    wr(0, 3, 32'd1);
    chk("t3_step_before", 32'(obs_step[0]), 32'd1);
    rd(0, 2);
    chk("t3_status", obs_data, 32'h0);
    chk("t3_step_after", 32'(obs_step[0]), 32'd0);
    chk("t3_irq", 32'(obs_irq), 32'd1);

    // Command while busy on ch2: error flag, original count completes.
    wr(2, 1, 32'd4);
    wr(2, 0, 32'd5);
    idle_count(2);
    ra = rises_a[2];
    wr(2, 0, 32'd50);
    idle_count(30);
    chk("t4_rises", 32'(ra + rises_a[2]), 32'd5);
    rd(2, 2);
    chk("t4_status", obs_data, 32'h6000_0000);
    wr(2, 3, 32'd2);
    rd(2, 2);
    chk("t4_cleared", obs_data, 32'h0);

    // Period clamp on ch3 and the zero-step command.
    wr(3, 1, 32'd1);
    wr(3, 0, 32'd4);
    idle_count(20);
    chk("t5_rises", 32'(rises_a[3]), 32'd4);
    chk("t5_gap_min", 32'(gmin_a[3]), 32'd3);
    chk("t5_gap_max", 32'(gmax_a[3]), 32'd3);
    chk("t5_high", 32'(high_a[3]), 32'd8);
    wr(3, 3, 32'd2);
    wr(3, 0, 32'd0);
    rd(3, 2);
    chk("t5_zero_done", obs_data, 32'h4000_0000);
    idle_count(5);
    chk("t5_zero_nopulse", 32'(rises_a[3] + high_a[3]), 32'd0);

    // Concurrent channels with different periods.
    wr(3, 1, 32'd14);
    wr(0, 0, 32'd3);
    wr(3, 0, 32'd2);
    idle_count(50);
    chk("t6_ch0_rises", 32'(rises_a[0]), 32'd2);
    chk("t6_ch0_gap", 32'(gmin_a[0]), 32'd10);
    chk("t6_ch3_rises", 32'(rises_a[3]), 32'd2);
    chk("t6_ch3_gap", 32'(gmax_a[3]), 32'd14);

    // Channel 7 does not exist.
    wr(7, 0, 32'd5);
    idle_count(6);
    chk("t6_ch7_nopulse", 32'(rises_a[0] + rises_a[1] + rises_a[2] + rises_a[3]), 32'd0);
    rd(7, 2);
    chk("t6_ch7_status", obs_data, 32'h0);

    // Reset in the middle of a move.
    wr(0, 0, 32'h8000_0005);
    idle_count(3);
    chk("t6_dir_before_rst", 32'(obs_dir[0]), 32'd1);
    chk("t6_irq_before_rst", 32'(obs_irq), 32'd1);
    cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    rd(0, 1);
    chk("t6_rst_period", obs_data, 32'(DEFP));
    chk("t6_rst_step", 32'(obs_step), 32'd0);
    chk("t6_rst_dir", 32'(obs_dir), 32'd0);
    chk("t6_rst_irq", 32'(obs_irq), 32'd0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      rsel = int'($urandom_range(0, 9));
      if (rsel < 4) begin
        cycle(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      end else begin
        ch  = (rsel == 9) ? int'($urandom_range(4, 7)) : int'($urandom_range(0, 3));
        rg  = int'($urandom_range(0, 3));
        rwe = 1'($urandom_range(0, 1));
        ra_addr = io_a(ch, rg);
        if ($urandom_range(0, 15) == 0) ra_addr[12] = 1'b0;
        case (rg)
          0:       rd_data = {1'($urandom_range(0, 1)), 15'h0, 16'($urandom_range(0, 5))};
          1:       rd_data = 32'($urandom_range(0, 12));
          3:       rd_data = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'd2;
          default: rd_data = $urandom;
        endcase
        cycle(1'b1, 1'b1, rwe, ra_addr, rd_data);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
